// File: rtl/prbs_checker_wide.sv
// Parallel PRBS checker (PN7/9/15/23/31): self-seeds from the received stream, locks, then counts bit errors.
// Optional build macro PRBS_CHK_INVERT_EN adds i_invert to check an inverted stream.
module prbs_checker_wide #(
    parameter int WIDTH      = 128,
    parameter int CNT_W      = 32,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 8
) (
    input  logic             i_clk,
    input  logic             i_s_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic [2:0]       i_pn_sel,
    input  logic             i_clr_cnt,
`ifdef PRBS_CHK_INVERT_EN
    input  logic             i_invert,
`endif
    output logic             o_locked,
    output logic             o_err_word,
    output logic [CNT_W-1:0] o_bit_err_cnt,
    output logic [CNT_W-1:0] o_word_cnt,
    output logic             o_lock_lost
);

    localparam int HIST_W = 31;
    localparam int POP_W  = $clog2(WIDTH + 1);
    localparam int SUM_W  = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int UNL_W  = $clog2(UNLOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [UNL_W-1:0]  UNL_LAST  = UNL_W'(UNLOCK_CNT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam int TAP_N [5] = '{7, 9, 15, 23, 31};
    localparam int TAP_M [5] = '{6, 5, 14, 18, 28};

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

    state_t              state;
    logic [HIST_W-1:0]   hist;
    logic [2:0]          pn_q;
    logic [GOOD_W-1:0]   good_cnt;
    logic [UNL_W-1:0]    unl_cnt;
    logic                s1_vld;
    logic [WIDTH-1:0]    s1_mask;

    logic [WIDTH-1:0]    data_in;
    logic                mode_chg;
    logic                pn_ok;
    logic [WIDTH-1:0]    exp_word;
    logic [HIST_W-1:0]   exp_tail;
    logic [WIDTH-1:0]    mask;
    logic                word_err;
    logic [POP_W-1:0]    pop;
    logic [SUM_W-1:0]    bit_sum;
    logic [CNT_W-1:0]    bit_sat;
    logic [CNT_W-1:0]    word_sat;

`ifdef PRBS_CHK_INVERT_EN
    logic inv_q;
    assign data_in  = i_invert ? ~i_data : i_data;
    assign mode_chg = (i_pn_sel != pn_q) || (i_invert != inv_q);
`else
    assign data_in  = i_data;
    assign mode_chg = (i_pn_sel != pn_q);
`endif

    assign pn_ok    = (pn_q <= 3'd4);
    assign o_locked = (state == ST_LOCKED);

    // hist[30] is the most recent bit; each polynomial extends it WIDTH bits in time order.
    for (genvar p = 0; p < 5; p++) begin : g_poly
        localparam int N = TAP_N[p];
        localparam int M = TAP_M[p];
        logic [WIDTH-1:0]  pred;
        logic [HIST_W-1:0] tail;

        always_comb begin : extend
            logic [WIDTH+HIST_W-1:0] ext;
            ext = '0;
            ext[HIST_W-1:0] = hist;
            for (int unsigned j = 0; j < WIDTH; j++) begin
                ext[HIST_W+j] = ext[HIST_W+j-N] ^ ext[HIST_W+j-M];
            end
            pred = ext[WIDTH+HIST_W-1:HIST_W];
            tail = ext[WIDTH+HIST_W-1:WIDTH];
        end
    end

    always_comb begin
        exp_word = '0;
        exp_tail = '0;
        case (pn_q)
            3'd0: begin exp_word = g_poly[0].pred; exp_tail = g_poly[0].tail; end
            3'd1: begin exp_word = g_poly[1].pred; exp_tail = g_poly[1].tail; end
            3'd2: begin exp_word = g_poly[2].pred; exp_tail = g_poly[2].tail; end
            3'd3: begin exp_word = g_poly[3].pred; exp_tail = g_poly[3].tail; end
            3'd4: begin exp_word = g_poly[4].pred; exp_tail = g_poly[4].tail; end
            default: ;
        endcase
    end

    assign mask     = data_in ^ exp_word;
    assign word_err = |mask;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pop = pop + POP_W'(s1_mask[i]);
        end
    end

    always_comb begin
        bit_sum  = SUM_W'(o_bit_err_cnt) + SUM_W'(pop);
        bit_sat  = (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bit_sum[CNT_W-1:0];
        word_sat = (o_word_cnt == CNT_MAX) ? CNT_MAX : o_word_cnt + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            state         <= ST_UNLOCKED;
            hist          <= '0;
            pn_q          <= '0;
            good_cnt      <= '0;
            unl_cnt       <= '0;
            s1_vld        <= 1'b0;
            s1_mask       <= '0;
            o_err_word    <= 1'b0;
            o_bit_err_cnt <= '0;
            o_word_cnt    <= '0;
            o_lock_lost   <= 1'b0;
`ifdef PRBS_CHK_INVERT_EN
            inv_q         <= 1'b0;
`endif
        end else begin
            s1_vld <= 1'b0;
            if (mode_chg) begin
                pn_q     <= i_pn_sel;
`ifdef PRBS_CHK_INVERT_EN
                inv_q    <= i_invert;
`endif
                state    <= ST_UNLOCKED;
                good_cnt <= '0;
                unl_cnt  <= '0;
            end else if (!pn_ok) begin
                state    <= ST_UNLOCKED;
                good_cnt <= '0;
                unl_cnt  <= '0;
            end else if (i_valid) begin
                case (state)
                    ST_UNLOCKED: begin
                        hist <= data_in[WIDTH-1 -: HIST_W];
                        if (word_err) begin
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                            if (good_cnt == GOOD_LAST) state <= ST_LOCKED;
                        end
                    end
                    ST_LOCKED: begin
                        hist    <= exp_tail;
                        s1_vld  <= 1'b1;
                        s1_mask <= mask;
                        if (word_err) begin
                            if (unl_cnt == UNL_LAST) begin
                                state       <= ST_UNLOCKED;
                                good_cnt    <= '0;
                                unl_cnt     <= '0;
                                o_lock_lost <= 1'b1;
                            end else begin
                                unl_cnt <= unl_cnt + 1'b1;
                            end
                        end else begin
                            unl_cnt <= '0;
                        end
                    end
                endcase
            end

            o_err_word <= s1_vld & (|s1_mask);
            // Clear wins over both the accumulation landing this edge and a new lock-loss event.
            if (i_clr_cnt) begin
                o_bit_err_cnt <= '0;
                o_word_cnt    <= '0;
                o_lock_lost   <= 1'b0;
            end else if (s1_vld) begin
                o_bit_err_cnt <= bit_sat;
                o_word_cnt    <= word_sat;
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker_wide.sv
// Scoreboard bench for prbs_checker_wide: bit-queue PRBS generator and reference model, per-cycle output checks.
module tb_prbs_checker_wide;

    localparam int WIDTH      = 128;
    localparam int CNT_W      = 8;
    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 8;
    localparam int CMAX       = (1 << CNT_W) - 1;
    localparam int TAP_N [5]  = '{7, 9, 15, 23, 31};
    localparam int TAP_M [5]  = '{6, 5, 14, 18, 28};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic [2:0]       pn_sel = '0;
    logic             clr = 1'b0;
    logic             locked, err_word, lock_lost;
    logic [CNT_W-1:0] bit_cnt, word_cnt;

    always #5 clk = ~clk;

    prbs_checker_wide #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
    ) dut (
        .i_clk(clk), .i_s_rst(rst), .i_valid(valid), .i_data(data), .i_pn_sel(pn_sel),
        .i_clr_cnt(clr), .o_locked(locked), .o_err_word(err_word),
        .o_bit_err_cnt(bit_cnt), .o_word_cnt(word_cnt), .o_lock_lost(lock_lost)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned tgt;
        logic        locked;
        logic        err_word;
        int          bits;
        int          words;
        logic        lost;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].tgt <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.tgt < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stale_entry at cycle %0d: got entry for cycle %0d, expected %0d", cyc, e.tgt, cyc);
            end else begin
                chk("locked",   32'(locked),    32'(e.locked));
                chk("err_word", 32'(err_word),  32'(e.err_word));
                chk("bit_cnt",  32'(bit_cnt),   32'(e.bits));
                chk("word_cnt", 32'(word_cnt),  32'(e.words));
                chk("lock_lost",32'(lock_lost), 32'(e.lost));
            end
        end
    end

    // Extend a bit history (oldest first) by WIDTH bits using b[k] = b[k-n] ^ b[k-m].
    function automatic logic [WIDTH-1:0] extend_q(input bit h[$], input logic [2:0] sel);
        bit q[$];
        bit nb;
        logic [WIDTH-1:0] w;
        int n, m;
        n = TAP_N[sel];
        m = TAP_M[sel];
        q = h;
        w = '0;
        for (int j = 0; j < WIDTH; j++) begin
            nb = q[q.size() - n] ^ q[q.size() - m];
            q.push_back(nb);
            w[j] = nb;
        end
        return w;
    endfunction

    bit         gen_q[$];
    logic [2:0] cur_sel = '0;

    function automatic logic [WIDTH-1:0] gen_word();
        logic [WIDTH-1:0] w;
        w = extend_q(gen_q, cur_sel);
        for (int j = 0; j < WIDTH; j++) gen_q.push_back(w[j]);
        while (gen_q.size() > 31) void'(gen_q.pop_front());
        return w;
    endfunction

    function automatic void set_mode(input logic [2:0] sel);
        cur_sel = sel;
        gen_q = {};
        for (int i = 0; i < 31; i++) gen_q.push_back(bit'($urandom_range(1)));
        gen_q[30] = 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [WIDTH-1:0] rand_mask(input int k);
        logic [WIDTH-1:0] fm;
        fm = '0;
        while ($countones(fm) < k) fm[$urandom_range(WIDTH-1)] = 1'b1;
        return fm;
    endfunction

    // Reference model state.
    logic [2:0] m_pn;
    bit         m_locked, m_lost;
    int         m_good, m_unl, m_bits, m_words;
    bit         m_q[$];
    bit         pend_v;
    int         pend_pop;

    function automatic void hist_push(input logic [WIDTH-1:0] w);
        for (int j = 0; j < WIDTH; j++) m_q.push_back(w[j]);
        while (m_q.size() > 31) void'(m_q.pop_front());
    endfunction

    function automatic void step(input logic v, input logic [WIDTH-1:0] d, input logic [2:0] ps,
                                 input logic c, input logic r);
        exp_t e;
        logic [WIDTH-1:0] pred, mk;
        e.tgt = cyc + 1;
        if (r) begin
            m_pn = '0; m_locked = 0; m_lost = 0; m_good = 0; m_unl = 0;
            m_bits = 0; m_words = 0; pend_v = 0; pend_pop = 0;
            m_q = {};
            for (int i = 0; i < 31; i++) m_q.push_back(1'b0);
            e.err_word = 1'b0;
        end else begin
            e.err_word = pend_v && (pend_pop != 0);
            if (c) begin
                m_bits = 0; m_words = 0;
            end else if (pend_v) begin
                m_bits  = (m_bits + pend_pop > CMAX) ? CMAX : m_bits + pend_pop;
                m_words = (m_words + 1 > CMAX) ? CMAX : m_words + 1;
            end
            pend_v = 0; pend_pop = 0;
            if (ps != m_pn) begin
                m_pn = ps; m_locked = 0; m_good = 0; m_unl = 0;
            end else if (m_pn > 3'd4) begin
                m_locked = 0; m_good = 0; m_unl = 0;
            end else if (v) begin
                pred = extend_q(m_q, m_pn);
                mk = d ^ pred;
                if (!m_locked) begin
                    hist_push(d);
                    if (mk != '0) m_good = 0;
                    else begin
                        m_good++;
                        if (m_good == LOCK_CNT) m_locked = 1;
                    end
                end else begin
                    hist_push(pred);
                    pend_v = 1;
                    pend_pop = $countones(mk);
                    if (mk != '0) begin
                        m_unl++;
                        if (m_unl == UNLOCK_CNT) begin
                            m_locked = 0; m_good = 0; m_unl = 0; m_lost = 1;
                        end
                    end else m_unl = 0;
                end
            end
            if (c) m_lost = 0;
        end
        e.locked = m_locked; e.bits = m_bits; e.words = m_words; e.lost = m_lost;
        sbq.push_back(e);
    endfunction

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [2:0] ps,
                         input logic c, input logic r);
        @(posedge clk);
        #1;
        valid = v; data = d; pn_sel = ps; clr = c; rst = r;
        step(v, d, ps, c, r);
    endtask

    task automatic send(input logic [WIDTH-1:0] fm);
        drive(1'b1, gen_word() ^ fm, cur_sel, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, rnd_word(), cur_sel, 1'b0, 1'b0);
    endtask

    task automatic gap_rand();
        if ($urandom_range(2) == 0) idle(1 + $urandom_range(2));
    endtask

    initial begin
        #400000;
        $display("FAIL timeout at cycle %0d: got no finish, expected finish", cyc);
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] fm;
        int r;
        set_mode(3'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 3'd0, 1'b0, 1'b1);

        // Lock on every polynomial, then a few locked words with 0..7 flipped bits and random gaps.
        for (int p = 0; p < 5; p++) begin
            set_mode(3'(p));
            for (int i = 0; i < 10; i++) begin send('0); gap_rand(); end
            for (int i = 0; i < 6; i++) begin send(rand_mask($urandom_range(7))); gap_rand(); end
        end

        fm = '0; fm[5] = 1'b1;
        send(fm); idle(3);
        send(rand_mask(7));
        for (int i = 0; i < 5; i++) begin gap_rand(); send('0); end
        idle(2);

        // Eight consecutive errored words drop lock; clean data relocks.
        for (int i = 0; i < 8; i++) send(rand_mask(1));
        for (int i = 0; i < 6; i++) send('0);
        idle(2);

        drive(1'b0, rnd_word(), cur_sel, 1'b1, 1'b0);
        idle(2);

        for (int i = 0; i < 3; i++) send(rand_mask(100));
        idle(3);
        send(rand_mask(5));
        drive(1'b0, rnd_word(), cur_sel, 1'b1, 1'b0);
        idle(3);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(99);
            if (r < 70) send((r < 8) ? rand_mask(1 + $urandom_range(3)) : '0);
            else drive(1'b0, rnd_word(), cur_sel, (r >= 97), 1'b0);
        end

        set_mode(3'd5);
        for (int i = 0; i < 20; i++) drive(1'b1, rnd_word(), 3'd5, 1'b0, 1'b0);

        set_mode(3'd1);
        for (int i = 0; i < 8; i++) send('0);
        send(rand_mask(3));
        drive(1'b0, rnd_word(), cur_sel, 1'b0, 1'b1);
        idle(4);

        for (int i = 0; i < 5 && sbq.size() > 0; i++) begin
            @(posedge clk);
            #6;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending entries, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prbs_checker_wide.md
Name: prbs_checker_wide

Overview:
- WIDTH-bit parallel PRBS checker with runtime-selectable polynomial (PN7/9/15/23/31).
- Self-seeds from the incoming stream and acquires lock. Once locked, it free-runs its own reference and counts bit errors exactly once per flipped bit.
- Sits at the receive end of loopback and link tests, paired with the prbs_wide generator.

Parameters:
- WIDTH, 128, data word width; legal range is 32 or greater, so one word can seed PN31.
- CNT_W, 32, width of the bit-error and word counters.
- LOCK_CNT, 4, consecutive error-free words required to acquire lock.
- UNLOCK_CNT, 8, consecutive errored words that force loss of lock.

Ports:
- i_clk  in  1  clock.
- i_s_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  i_data holds a word this cycle.
- i_data  in  WIDTH  received word; bit 0 is the earliest bit in time.
- i_pn_sel  in  3  polynomial select: 0=PN7 x^7+x^6+1, 1=PN9 x^9+x^5+1, 2=PN15 x^15+x^14+1, 3=PN23 x^23+x^18+1, 4=PN31 x^31+x^28+1; 5-7 invalid.
- i_clr_cnt  in  1  clears the counters and o_lock_lost.
- o_locked  out  1  checker is in LOCKED.
- o_err_word  out  1  one-cycle pulse: the checked word contained at least one bit error (LOCKED only).
- o_bit_err_cnt  out  CNT_W  saturating count of bit errors while locked.
- o_word_cnt  out  CNT_W  saturating count of words checked while locked.
- o_lock_lost  out  1  sticky flag: the checker went from LOCKED to UNLOCKED.

Behaviour:
- Reset: every output is 0, state is UNLOCKED, reference state and lock/unlock counters are 0.
- Recurrence: for polynomial x^n+x^m+1, b[k] = b[k-n] ^ b[k-m].
- Prediction: the reference is the last n bits of the previous word. The expected word is these n bits extended WIDTH bits by the recurrence.
- UNLOCKED:
  - On each i_valid word, compare against the prediction seeded from the previous valid word's last n bits, then reseed from this word.
  - Error-free word: good counter +1. Errored word: good counter cleared.
  - Good counter reaching LOCK_CNT moves the state to LOCKED; the reference keeps free-running from the current state.
  - No error or count outputs change in UNLOCKED.
- LOCKED:
  - Reference advances WIDTH bits per valid word from its own prediction; it is never reseeded from data.
  - Error mask = i_data ^ expected; popcount(mask) is added to o_bit_err_cnt; o_word_cnt +1.
  - Each errored word increments the unlock counter; each clean word clears it.
  - Unlock counter reaching UNLOCK_CNT sets state to UNLOCKED, clears the good counter and sets o_lock_lost.
- i_valid low: no state, reference or counter changes. Gaps of any length are allowed.
- Pipeline: stage 1 registers the error mask, stage 2 registers the popcount and accumulation.
  - o_err_word, o_bit_err_cnt and o_word_cnt reflect a word exactly 2 cycles after its i_valid cycle.
  - o_locked rises 1 cycle after the LOCK_CNT-th clean word.
- Counters saturate at 2^CNT_W-1 and never wrap. Popcount width is clog2(WIDTH+1).
- i_clr_cnt:
  - Clears o_bit_err_cnt, o_word_cnt and o_lock_lost on the next edge.
  - Has priority over a simultaneous increment; that word's contribution is discarded.
  - Does not affect lock state.
- Change of i_pn_sel (registered compare):
  - Forces UNLOCKED next cycle and clears the good and unlock counters.
  - Does not set o_lock_lost; counters are kept.
  - Words already in flight in the pipeline still update the counters.
- Invalid i_pn_sel (5-7): held in UNLOCKED, o_locked stays 0, no counting.
- Reset mid-operation: returns to the reset state on the next edge; the pipeline is flushed and no pulse is emitted.

Optional Feature:
- Macro PRBS_CHK_INVERT_EN.
- When defined: adds port i_invert (in, 1). When 1, i_data is bit-inverted before the checker, so the o_prbs_n output of prbs_wide checks clean. A change of i_invert is handled like an i_pn_sel change (forces UNLOCKED).
- When undefined: the port is absent and data is checked uninverted.

Test Plan:
- Clean lock: prbs_wide PN7, WIDTH=128 feeding i_data, continuous valid -> o_locked=1 one cycle after the 4th clean word. o_bit_err_cnt stays 0 and o_word_cnt increments by 1 per word.
- Single-bit error: while locked, flip i_data[5] in one word -> o_err_word pulses once, 2 cycles later. o_bit_err_cnt=1 (not 3) and o_locked stays 1.
- Multi-bit and gaps: flip 7 bits in one word, toggle i_valid 0/1 randomly -> o_bit_err_cnt=7 and lock is held through the gaps.
- Loss of lock: feed 8 consecutive words, each with one flipped bit -> o_locked falls after the 8th, o_lock_lost=1, o_bit_err_cnt=8. Clean data then relocks after 4 words.
- Mode sweep: for pn_sel 0-4, generator set to the matching PN -> lock each time. pn_sel=5 -> o_locked=0 and counters frozen.
- Clear/saturation: CNT_W=4, 20 errors -> o_bit_err_cnt=15. i_clr_cnt asserted with an errored word -> counter 0 and o_lock_lost 0.
